// File: rtl/dynode_energy_arbiter.sv
// dynode_energy_arbiter
//   Collects energy records from NCH integrator channels and serialises them onto a single
//   valid/ready readout stream. Integrator strobes cannot be stalled, so every channel owns
//   a 1-deep holding slot; a strobe that finds its slot still occupied is dropped and counted.
//   Grants are round-robin starting at the channel after the last one granted.
//
//   Optional feature macro: DYN_ARB_THRESH_EN
//     When defined, the ene_thresh port exists and strobes whose energy is below it are
//     ignored entirely (no capture, no drop, no overflow).
//
// Ports
//   clk, reset_n      rising-edge clock, asynchronous active-low reset
//   arb_en            1 = new grants allowed (capture always continues)
//   cnt_clr           synchronous clear of drop_cnt and ovf_flag (wins over same-cycle drops)
//   ene_load          per-channel record strobe
//   dyn_energy/evntim/ingcnt  packed per-channel record fields (12/24/4 bits per channel)
//   ene_thresh        energy threshold (DYN_ARB_THRESH_EN only)
//   out_valid/out_ready       readout handshake
//   out_chan/energy/evntim/ingcnt  registered output record
//   pend              slot-occupied flags
//   ovf_flag          sticky per-channel overflow flags
//   drop_cnt          saturating count of dropped records
module dynode_energy_arbiter #(
    parameter int  NCH    = 4,
    parameter int  DCNT_W = 16,
    localparam int CHW    = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                arb_en,
    input  logic                cnt_clr,
    input  logic [NCH-1:0]      ene_load,
    input  logic [NCH*12-1:0]   dyn_energy,
    input  logic [NCH*24-1:0]   dyn_evntim,
    input  logic [NCH*4-1:0]    dyn_ingcnt,
`ifdef DYN_ARB_THRESH_EN
    input  logic [11:0]         ene_thresh,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW-1:0]      out_chan,
    output logic [11:0]         out_energy,
    output logic [23:0]         out_evntim,
    output logic [3:0]          out_ingcnt,
    output logic [NCH-1:0]      pend,
    output logic [NCH-1:0]      ovf_flag,
    output logic [DCNT_W-1:0]   drop_cnt
);
    typedef struct packed {
        logic [11:0] energy;
        logic [23:0] evntim;
        logic [3:0]  ingcnt;
    } rec_t;

    typedef enum logic {S_IDLE, S_OUT} state_t;

    state_t            state_q;
    rec_t              slot_q [NCH];
    rec_t              out_q;
    rec_t              rec_in [NCH];
    logic              out_valid_q;
    logic [CHW-1:0]    chan_q, rr_ptr_q, rr_ptr_d, cand;
    logic [NCH-1:0]    pend_q, pend_d, ovf_q, ovf_d;
    logic [NCH-1:0]    take, cap, drop;
    logic [DCNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DCNT_W:0]   ndrop, dsum;
    logic              found, grant;

    always_comb begin
        // Round-robin search: first pending slot at or after rr_ptr, wrapping.
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && pend_q[(int'(rr_ptr_q) + k) % NCH]) begin
                found = 1'b1;
                cand  = CHW'((int'(rr_ptr_q) + k) % NCH);
            end
        end

        // A grant is possible from idle, or back-to-back when the current record is accepted.
        grant    = arb_en && found && (state_q == S_IDLE || out_ready);
        rr_ptr_d = (int'(cand) == NCH - 1) ? '0 : cand + CHW'(1);

        ndrop = '0;
        for (int i = 0; i < NCH; i++) begin
            rec_in[i] = {dyn_energy[12*i +: 12], dyn_evntim[24*i +: 24], dyn_ingcnt[4*i +: 4]};
`ifdef DYN_ARB_THRESH_EN
            take[i]   = ene_load[i] && (dyn_energy[12*i +: 12] >= ene_thresh);
`else
            take[i]   = ene_load[i];
`endif
            // A slot emptied by this cycle's grant can accept a new record in the same cycle.
            cap[i]    = take[i] && (!pend_q[i] || (grant && cand == CHW'(i)));
            drop[i]   = take[i] && !cap[i];
            ndrop     = ndrop + (DCNT_W+1)'(drop[i]);
        end

        pend_d = pend_q;
        if (grant) pend_d[cand] = 1'b0;
        pend_d = pend_d | cap;

        dsum       = {1'b0, drop_cnt_q} + ndrop;
        drop_cnt_d = dsum[DCNT_W] ? '1 : dsum[DCNT_W-1:0];
        ovf_d      = ovf_q | drop;
        if (cnt_clr) begin
            drop_cnt_d = '0;
            ovf_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            chan_q      <= '0;
            rr_ptr_q    <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < NCH; i++) slot_q[i] <= '0;
        end else begin
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NCH; i++)
                if (cap[i]) slot_q[i] <= rec_in[i];

            // Output regs read the slot's old contents; a same-cycle capture lands after.
            if (grant) begin
                out_q    <= slot_q[cand];
                chan_q   <= cand;
                rr_ptr_q <= rr_ptr_d;
            end

            case (state_q)
                S_IDLE: if (grant) begin
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                // Held record is only released by out_ready; arb_en low just blocks the next grant.
                S_OUT: if (out_ready && !grant) begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_chan   = chan_q;
    assign out_energy = out_q.energy;
    assign out_evntim = out_q.evntim;
    assign out_ingcnt = out_q.ingcnt;
    assign pend       = pend_q;
    assign ovf_flag   = ovf_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_dynode_energy_arbiter.sv
// Bench for dynode_energy_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level reference model (slots, round-robin pointer, output record, counters).
module tb_dynode_energy_arbiter;
    localparam int NCH    = 4;
    localparam int DCNT_W = 4;   // narrow so saturation is reachable
    localparam int CHW    = 2;
    localparam int DMAX   = (1 << DCNT_W) - 1;
    localparam int EW     = NCH * 12;
    localparam int TW     = NCH * 24;
    localparam int NW     = NCH * 4;

    logic              clk = 1'b0, reset_n = 1'b0, arb_en = 1'b0, cnt_clr = 1'b0, out_ready = 1'b0;
    logic [NCH-1:0]    ene_load = '0;
    logic [EW-1:0]     dyn_energy = '0;
    logic [TW-1:0]     dyn_evntim = '0;
    logic [NW-1:0]     dyn_ingcnt = '0;
`ifdef DYN_ARB_THRESH_EN
    logic [11:0]       ene_thresh = '0;
`endif
    logic              out_valid;
    logic [CHW-1:0]    out_chan;
    logic [11:0]       out_energy;
    logic [23:0]       out_evntim;
    logic [3:0]        out_ingcnt;
    logic [NCH-1:0]    pend, ovf_flag;
    logic [DCNT_W-1:0] drop_cnt;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dynode_energy_arbiter #(.NCH(NCH), .DCNT_W(DCNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .arb_en(arb_en), .cnt_clr(cnt_clr),
        .ene_load(ene_load), .dyn_energy(dyn_energy), .dyn_evntim(dyn_evntim),
        .dyn_ingcnt(dyn_ingcnt),
`ifdef DYN_ARB_THRESH_EN
        .ene_thresh(ene_thresh),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_energy(out_energy), .out_evntim(out_evntim), .out_ingcnt(out_ingcnt),
        .pend(pend), .ovf_flag(ovf_flag), .drop_cnt(drop_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct packed { logic [11:0] e; logic [23:0] t; logic [3:0] n; } rec_t;
    rec_t           m_slot [NCH];
    logic [NCH-1:0] m_pend, m_ovf;
    rec_t           m_out;
    int             m_rr, m_chan, m_drop;
    logic           m_valid;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) m_slot[i] = '0;
        m_pend = '0; m_ovf = '0; m_out = '0;
        m_rr = 0; m_chan = 0; m_drop = 0; m_valid = 1'b0;
    endfunction

    // One clock edge worth of behaviour, from the inputs currently applied.
    function automatic void model_step();
        int   g;
        int   drops;
        rec_t r;
        g = -1; drops = 0;
        for (int k = 0; k < NCH; k++)
            if (g < 0 && m_pend[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
        if (arb_en && g >= 0 && (!m_valid || out_ready)) begin
            m_out = m_slot[g]; m_chan = g; m_valid = 1'b1;
            m_pend[g] = 1'b0; m_rr = (g + 1) % NCH;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (!ene_load[i]) continue;
`ifdef DYN_ARB_THRESH_EN
            if (dyn_energy[12*i +: 12] < ene_thresh) continue;
`endif
            r = {dyn_energy[12*i +: 12], dyn_evntim[24*i +: 24], dyn_ingcnt[4*i +: 4]};
            if (!m_pend[i]) begin
                m_pend[i] = 1'b1; m_slot[i] = r;
            end else begin
                drops++; m_ovf[i] = 1'b1;
            end
        end
        m_drop = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
        if (cnt_clr) begin m_drop = 0; m_ovf = '0; end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk); #1;
        ene_load = '0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; model_reset();
        ene_load = '0; cnt_clr = 1'b0;
        #12 reset_n = 1'b1;
    endtask

    task automatic set_ch(input int c, input logic [11:0] e, input logic [23:0] t, input logic [3:0] n);
        ene_load[c] = 1'b1;
        dyn_energy[12*c +: 12] = e;
        dyn_evntim[24*c +: 24] = t;
        dyn_ingcnt[4*c +: 4]   = n;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; model_reset(); #3;
        n_cmp++;
        if ({out_valid, pend, ovf_flag, drop_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_status got v=%b pend=%b ovf=%b drop=%0d want all 0",
                              out_valid, pend, ovf_flag, drop_cnt);
        end
        n_cmp++;
        if ({out_chan, out_energy, out_evntim, out_ingcnt} !== '0) begin
            n_bad++; $display("FAIL reset_data got chan=%0d e=%h t=%h n=%h want 0",
                              out_chan, out_energy, out_evntim, out_ingcnt);
        end
        #9 reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset(); arb_en = 1'b1; out_ready = 1'b1;
        set_ch(2, 12'h1A5, 24'h123456, 4'h4);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || pend !== 4'b0100) begin
            n_bad++; $display("FAIL single_pend got v=%b pend=%b want v=0 pend=0100", out_valid, pend);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_chan, out_energy, out_evntim, out_ingcnt, pend} !==
            {1'b1, 2'd2, 12'h1A5, 24'h123456, 4'h4, 4'b0000}) begin
            n_bad++; $display("FAIL single_out got v=%b ch=%0d e=%h t=%h n=%h pend=%b want 1/2/1a5/123456/4/0000",
                              out_valid, out_chan, out_energy, out_evntim, out_ingcnt, pend);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_drop_valid got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset(); arb_en = 1'b1; out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++)
                set_ch(c, 12'(12'h300 + 16*r + c), 24'(1000*c + r), 4'(c + 1));
            tick();
            for (int k = 0; k < NCH; k++) begin
                tick();
                n_cmp++;
                if (out_valid !== 1'b1 || out_chan !== CHW'(k) || out_energy !== 12'(12'h300 + 16*r + k)) begin
                    n_bad++; $display("FAIL rr_order round %0d slot %0d got v=%b ch=%0d e=%h want v=1 ch=%0d e=%h",
                                      r, k, out_valid, out_chan, out_energy, k, 12'(12'h300 + 16*r + k));
                end
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || pend !== '0) begin
                n_bad++; $display("FAIL rr_idle round %0d got v=%b pend=%b want 0/0000", r, out_valid, pend);
            end
        end
    endtask

    // Output held with ready low: 1st record sits in the output regs, 2nd fills the freed slot,
    // 3rd finds the slot busy and is dropped.
    task automatic test_backpressure();
        do_reset(); arb_en = 1'b1; out_ready = 1'b0;
        set_ch(1, 12'h0A1, 24'hA1A1A1, 4'h1); tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) set_ch(1, 12'h0B2, 24'hB2B2B2, 4'h2);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_energy !== 12'h0A1 || out_evntim !== 24'hA1A1A1) begin
                n_bad++; $display("FAIL bp_hold cyc %0d got v=%b ch=%0d e=%h t=%h want 1/1/0a1/a1a1a1",
                                  k, out_valid, out_chan, out_energy, out_evntim);
            end
        end
        repeat (4) tick();
        set_ch(1, 12'h0C3, 24'hC3C3C3, 4'h3); tick();
        n_cmp++;
        if (drop_cnt !== 4'd1 || ovf_flag !== 4'b0010 || pend !== 4'b0010 || out_energy !== 12'h0A1) begin
            n_bad++; $display("FAIL bp_drop got drop=%0d ovf=%b pend=%b e=%h want 1/0010/0010/0a1",
                              drop_cnt, ovf_flag, pend, out_energy);
        end
        out_ready = 1'b1; tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_energy !== 12'h0B2 || out_ingcnt !== 4'h2) begin
            n_bad++; $display("FAIL bp_second got v=%b ch=%0d e=%h n=%h want 1/1/0b2/2",
                              out_valid, out_chan, out_energy, out_ingcnt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || pend !== '0 || drop_cnt !== 4'd1) begin
            n_bad++; $display("FAIL bp_end got v=%b pend=%b drop=%0d want 0/0000/1", out_valid, pend, drop_cnt);
        end
    endtask

    task automatic test_free_load();
        do_reset(); arb_en = 1'b1; out_ready = 1'b1;
        set_ch(0, 12'h011, 24'h000011, 4'h1); tick();
        set_ch(0, 12'h022, 24'h000022, 4'h2); tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_energy !== 12'h011 || pend !== 4'b0001 || drop_cnt !== '0) begin
            n_bad++; $display("FAIL free_first got v=%b ch=%0d e=%h pend=%b drop=%0d want 1/0/011/0001/0",
                              out_valid, out_chan, out_energy, pend, drop_cnt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_energy !== 12'h022 || pend !== 4'b0000) begin
            n_bad++; $display("FAIL free_second got v=%b ch=%0d e=%h pend=%b want 1/0/022/0000",
                              out_valid, out_chan, out_energy, pend);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || drop_cnt !== '0 || ovf_flag !== '0) begin
            n_bad++; $display("FAIL free_end got v=%b drop=%0d ovf=%b want 0/0/0000", out_valid, drop_cnt, ovf_flag);
        end
    endtask

    task automatic test_arb_en_reset();
        int exp_ch [3] = '{0, 2, 3};
        do_reset(); arb_en = 1'b0; out_ready = 1'b1;
        set_ch(0, 12'h0D0, 24'h0, 4'h0); set_ch(2, 12'h0D2, 24'h2, 4'h2); set_ch(3, 12'h0D3, 24'h3, 4'h3);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || pend !== 4'b1101) begin
                n_bad++; $display("FAIL arb_off cyc %0d got v=%b pend=%b want 0/1101", k, out_valid, pend);
            end
        end
        arb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_chan !== CHW'(exp_ch[k])) begin
                n_bad++; $display("FAIL arb_on rec %0d got v=%b ch=%0d want 1/%0d", k, out_valid, out_chan, exp_ch[k]);
            end
        end
        tick();
        out_ready = 1'b0;
        set_ch(1, 12'h0E1, 24'h1, 4'h1); set_ch(2, 12'h0E2, 24'h2, 4'h2); tick();
        tick();
        set_ch(2, 12'h0F2, 24'h2, 4'h2); tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || drop_cnt !== 4'd1 || pend !== 4'b0100) begin
            n_bad++; $display("FAIL pre_reset got v=%b ch=%0d drop=%0d pend=%b want 1/1/1/0100",
                              out_valid, out_chan, drop_cnt, pend);
        end
        #2 reset_n = 1'b0; model_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || pend !== '0 || drop_cnt !== '0 || ovf_flag !== '0) begin
            n_bad++; $display("FAIL async_reset got v=%b pend=%b drop=%0d ovf=%b want all 0",
                              out_valid, pend, drop_cnt, ovf_flag);
        end
        #4 reset_n = 1'b1;
    endtask

    task automatic test_saturate();
        do_reset(); arb_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < NCH; c++) set_ch(c, 12'(k), 24'(c), 4'(k));
            tick();
        end
        n_cmp++;
        if (drop_cnt !== 4'hF || ovf_flag !== 4'b1111) begin
            n_bad++; $display("FAIL saturate got drop=%0d ovf=%b want 15/1111", drop_cnt, ovf_flag);
        end
        for (int c = 0; c < NCH; c++) set_ch(c, 12'h0, 24'h0, 4'h0);
        cnt_clr = 1'b1; tick();
        n_cmp++;
        if (drop_cnt !== '0 || ovf_flag !== '0 || pend !== 4'b1111) begin
            n_bad++; $display("FAIL clr_wins got drop=%0d ovf=%b pend=%b want 0/0000/1111", drop_cnt, ovf_flag, pend);
        end
    endtask

`ifdef DYN_ARB_THRESH_EN
    task automatic test_thresh();
        do_reset(); arb_en = 1'b1; out_ready = 1'b1; ene_thresh = 12'h100;
        set_ch(0, 12'h0FF, 24'h0000FF, 4'h1); set_ch(1, 12'h100, 24'h000100, 4'h2); tick();
        n_cmp++;
        if (pend !== 4'b0010) begin
            n_bad++; $display("FAIL thresh_pend got pend=%b want 0010", pend);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_energy !== 12'h100) begin
            n_bad++; $display("FAIL thresh_out got v=%b ch=%0d e=%h want 1/1/100", out_valid, out_chan, out_energy);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || drop_cnt !== '0 || ovf_flag !== '0) begin
            n_bad++; $display("FAIL thresh_end got v=%b drop=%0d ovf=%b want 0/0/0000", out_valid, drop_cnt, ovf_flag);
        end
        ene_thresh = '0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < NCH; c++) ene_load[c] = ($urandom_range(0, 99) < 35);
            dyn_energy = EW'({$urandom(), $urandom()});
            dyn_evntim = TW'({$urandom(), $urandom(), $urandom()});
            dyn_ingcnt = NW'($urandom());
            out_ready  = ($urandom_range(0, 9) < 7);
            arb_en     = ($urandom_range(0, 9) < 9);
            cnt_clr    = ($urandom_range(0, 99) == 0);
`ifdef DYN_ARB_THRESH_EN
            if (cyc % 50 == 0) ene_thresh = 12'($urandom_range(0, 2047));
`endif
            tick();
            n_cmp++;
            if ({out_valid, out_chan, out_energy, out_evntim, out_ingcnt} !==
                {m_valid, CHW'(m_chan), m_out}) begin
                n_bad++; $display("FAIL rand_out cyc %0d got v=%b ch=%0d rec=%h want v=%b ch=%0d rec=%h",
                                  cyc, out_valid, out_chan, {out_energy, out_evntim, out_ingcnt},
                                  m_valid, m_chan, m_out);
            end
            n_cmp++;
            if ({pend, ovf_flag, drop_cnt} !== {m_pend, m_ovf, DCNT_W'(m_drop)}) begin
                n_bad++; $display("FAIL rand_status cyc %0d got pend=%b ovf=%b drop=%0d want pend=%b ovf=%b drop=%0d",
                                  cyc, pend, ovf_flag, drop_cnt, m_pend, m_ovf, m_drop);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_free_load();
        test_arb_en_reset();
        test_saturate();
`ifdef DYN_ARB_THRESH_EN
        test_thresh();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
